// File: rtl/lsu_wait.sv
// Load/store unit with a fixed number of wait states and a word-wide data memory.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half and word accesses.
module lsu_wait #(
  parameter int DEPTH = 2048,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] WCNT   = 4'(WAIT);
  localparam bit         NOWAIT = (WAIT == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic        c_we;
  logic [1:0]  c_size;
  logic        c_uns;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  logic          accept;
  logic          fire;
  logic          over;
  logic          misal;
  logic          fault;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld;
  logic [3:0]    wmask;
  logic [31:0]   wd;

  // With no wait states the access happens on the accepting edge,
  // so the live inputs stand in for the not-yet-captured fields.
  always_comb begin
    if (state == S_IDLE) begin
      c_we    = we;
      c_size  = size;
      c_uns   = uns;
      c_addr  = addr;
      c_wdata = wdata;
    end else begin
      c_we    = we_q;
      c_size  = size_q;
      c_uns   = uns_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
  end

  // ack blocks acceptance so consecutive requests see an idle cycle
  assign accept = (state == S_IDLE) && req && !ack;
  assign fire   = !reset &&
                  ((accept && NOWAIT) ||
                   (state == S_WAIT && cnt == 4'd1));

  assign over = {2'b00, c_addr[31:2]} >= 32'(DEPTH);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misal = (c_size == 2'b01 && c_addr[0]) ||
                 (c_size == 2'b10 && c_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign fault = over || (c_size == 2'b11) || misal;

  assign idx     = c_addr[AW+1:2];
  assign rd_word = mem[idx];
  assign lane_b  = rd_word[{c_addr[1:0], 3'b000} +: 8];
  assign lane_h  = c_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld = rd_word;
    case (c_size)
      2'b00:   ld = {{24{~c_uns & lane_b[7]}}, lane_b};
      2'b01:   ld = {{16{~c_uns & lane_h[15]}}, lane_h};
      default: ld = rd_word;
    endcase
  end

  always_comb begin
    wmask = 4'b1111;
    wd    = c_wdata;
    case (c_size)
      2'b00: begin
        wmask = 4'b0001 << c_addr[1:0];
        wd    = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        wmask = c_addr[1] ? 4'b1100 : 4'b0011;
        wd    = {2{c_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fire && c_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      ack <= 1'b0;
      if (fire) begin
        err   <= fault;
        rdata <= (fault || c_we) ? 32'd0 : ld;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (NOWAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WCNT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ack   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall = req & ~ack;

endmodule

// File: tb/tb_lsu_wait.sv
// Bench for lsu_wait: three instances (0, 3 and 2 wait states) against a
// transaction-level model, plus directed accesses with literal expectations.
module tb_lsu_wait;

  localparam int DEPTH = 2048;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        uns   = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        req   [3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        stall [3];

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_wait #(
      .DEPTH (DEPTH),
      .WAIT  (g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req[g]),
      .we    (we),
      .size  (size),
      .uns   (uns),
      .addr  (addr),
      .wdata (wdata),
      .ack   (ack[g]),
      .rdata (rdata[g]),
      .err   (err[g]),
      .stall (stall[g])
    );
  end

  function automatic int wt(int d);
    return d == 0 ? 0 : (d == 1 ? 3 : 2);
  endfunction

  // ---------------- behavioural model ----------------
  int          pend [3] = '{-1, -1, -1};
  logic        eack [3] = '{1'b0, 1'b0, 1'b0};
  logic        eerr [3];
  logic        ewe  [3];
  logic [31:0] erd  [3];
  logic        cwe  [3];
  logic [1:0]  csz  [3];
  logic        cu   [3];
  logic [31:0] ca   [3];
  logic [31:0] cwd  [3];
  logic [31:0] mm   [3][DEPTH];

  function automatic logic fault_of(logic [1:0] sz, logic [31:0] a);
    logic f;
    f = ((a >> 2) >= DEPTH) || (sz == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    if (sz == 2'b01 && (a % 2) != 0) f = 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] sz,
                                      logic u, logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'b10) return w;
    if (sz == 2'b00) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 128) v = v - 256;
    end else begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [1:0] sz,
                                        logic [31:0] a, logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (sz == 2'b00) begin
      m = 32'hFF;
      sh = 8 * int'(a % 4);
    end else if (sz == 2'b01) begin
      m = 32'hFFFF;
      sh = 16 * int'((a / 2) % 2);
    end else begin
      m = 32'hFFFF_FFFF;
      sh = 0;
    end
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  // Request accepted from idle; ack expected WAIT+1 edges later for one cycle.
  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        pend[d] = -1;
        eack[d] = 1'b0;
      end else if (pend[d] > 1) begin
        pend[d]--;
      end else if (pend[d] == 1) begin
        pend[d] = 0;
        eack[d] = 1'b1;
        eerr[d] = fault_of(csz[d], ca[d]);
        ewe[d]  = cwe[d];
        erd[d]  = 32'd0;
        if (!eerr[d]) begin
          if (cwe[d])
            mm[d][ca[d][12:2]] = merge(mm[d][ca[d][12:2]], csz[d], ca[d], cwd[d]);
          else
            erd[d] = ext(mm[d][ca[d][12:2]], csz[d], cu[d], ca[d]);
        end
      end else if (pend[d] == 0) begin
        pend[d] = -1;
        eack[d] = 1'b0;
      end else if (req[d]) begin
        cwe[d]  = we;
        csz[d]  = size;
        cu[d]   = uns;
        ca[d]   = addr;
        cwd[d]  = wdata;
        pend[d] = wt(d) + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        for (int d = 0; d < 3; d++) begin
          logic bad;
          bad = (ack[d] !== eack[d]) || (stall[d] !== (req[d] & ~eack[d]));
          if (eack[d]) begin
            if (err[d] !== eerr[d]) bad = 1'b1;
            if ((!ewe[d] || eerr[d]) && rdata[d] !== erd[d]) bad = 1'b1;
          end
          nvec++;
          if (bad) begin
            nbad++;
            $display("FAIL cycle dut%0d t=%0t: ack=%b stall=%b err=%b rdata=%h required ack=%b stall=%b err=%b rdata=%h",
                     d, $time, ack[d], stall[d], err[d], rdata[d],
                     eack[d], req[d] & ~eack[d], eerr[d], erd[d]);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic acc(input int d, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic e,
                     output int lat, output int nst);
    bit got;
    got = 1'b0;
    lat = 0;
    nst = 0;
    rd  = 32'd0;
    e   = 1'b0;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    req[d] = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        we = ~w; size = ~sz; uns = ~u; addr = ~a; wdata = ~wd;
      end
      if (ack[d]) begin
        got = 1'b1;
        lat = i - 1;
        rd  = rdata[d];
        e   = err[d];
      end else if (stall[d]) begin
        nst++;
      end
    end
    req[d] = 1'b0;
    if (!got) begin
      nvec++;
      nbad++;
      $display("FAIL timeout dut%0d addr %h: no ack in 40 cycles, required one", d, a);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, nst;

    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ack%0d", i), 32'(ack[i]), 32'd0);
      chk($sformatf("reset_err%0d", i), 32'(err[i]), 32'd0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
    end
    reset = 1'b0;

    // zero wait states
    acc(0, 1'b1, 2'b10, 1'b0, 32'h64, 32'hDEADBEEF, rd, e, lat, nst);
    chk("w0_sw_lat", lat, 1);
    chk("w0_sw_err", 32'(e), 0);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h64, 32'h0, rd, e, lat, nst);
    chk("w0_lw_lat", lat, 1);
    chk("w0_lw_data", rd, 32'hDEADBEEF);
    chk("w0_lw_err", 32'(e), 0);

    // three wait states, byte merge
    acc(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, rd, e, lat, nst);
    acc(1, 1'b1, 2'b00, 1'b0, 32'h42, 32'h000000AA, rd, e, lat, nst);
    chk("w3_sb_stall", nst, 4);
    acc(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, e, lat, nst);
    chk("w3_lw_stall", nst, 4);
    chk("w3_lw_lat", lat, 4);
    chk("w3_lw_data", rd, 32'h11AA3344);

    // sign and zero extension
    acc(0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h8000F0FF, rd, e, lat, nst);
    acc(0, 1'b0, 2'b00, 1'b0, 32'h80, 32'h0, rd, e, lat, nst);
    chk("lb", rd, 32'hFFFFFFFF);
    acc(0, 1'b0, 2'b00, 1'b1, 32'h80, 32'h0, rd, e, lat, nst);
    chk("lbu", rd, 32'h000000FF);
    acc(0, 1'b0, 2'b01, 1'b0, 32'h82, 32'h0, rd, e, lat, nst);
    chk("lh", rd, 32'hFFFF8000);
    acc(0, 1'b0, 2'b01, 1'b1, 32'h82, 32'h0, rd, e, lat, nst);
    chk("lhu", rd, 32'h00008000);

    // faults
    acc(2, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADF00D, rd, e, lat, nst);
    chk("w2_sw_lat", lat, 3);
    acc(2, 1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, rd, e, lat, nst);
    chk("oob_lw_err", 32'(e), 1);
    chk("oob_lw_data", rd, 32'd0);
    acc(2, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rd, e, lat, nst);
    chk("sz11_err", 32'(e), 1);
    acc(2, 1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h5A5A5A5A, rd, e, lat, nst);
    chk("top_sw_err", 32'(e), 0);
    acc(2, 1'b1, 2'b10, 1'b0, 32'h2000, 32'hFFFFFFFF, rd, e, lat, nst);
    chk("oob_sw_err", 32'(e), 1);
    acc(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat, nst);
    chk("fault_nowrite", rd, 32'h0BADF00D);

    // reset one cycle after acceptance abandons the store
    @(negedge clk);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h10; wdata = 32'h12345678;
    req[2] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abandon_ack", 32'(ack[2]), 0);
    chk("abandon_rdata", rdata[2], 0);
    @(negedge clk);
    reset = 1'b0;
    req[2] = 1'b0;
    repeat (4) @(negedge clk);
    acc(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat, nst);
    chk("abandon_data", rd, 32'h0BADF00D);
    chk("abandon_lat", lat, 3);

    // misaligned half store
    acc(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEBABE, rd, e, lat, nst);
    acc(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h00005566, rd, e, lat, nst);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("sh21_err", 32'(e), 1);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat, nst);
    chk("sh21_data", rd, 32'hCAFEBABE);
`else
    chk("sh21_err", 32'(e), 0);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat, nst);
    chk("sh21_data", rd, 32'hCAFE5566);
`endif

    // reset during the ack cycle drops ack at once; memory survives
    acc(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, e, lat, nst);
    reset = 1'b1;
    #1;
    chk("resp_reset_ack", 32'(ack[1]), 0);
    @(negedge clk);
    reset = 1'b0;
    acc(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, e, lat, nst);
    chk("mem_kept", rd, 32'h11AA3344);
    acc(1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, rd, e, lat, nst);
    chk("lh_hi", rd, 32'h000011AA);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, required completion");
    $fatal(1);
  end

endmodule
